// File: rtl/press_pkg.sv
// rtl/press_pkg.sv - state encoding and event codes shared by the press classifier
package press_pkg;

  typedef logic [2:0] press_state_t;

  localparam press_state_t ST_IDLE      = 3'd0;
  localparam press_state_t ST_PRESS1    = 3'd1;
  localparam press_state_t ST_GAP       = 3'd2;
  localparam press_state_t ST_PRESS2    = 3'd3;
  localparam press_state_t ST_LONG_HOLD = 3'd4;

  typedef enum logic [1:0] {
    EV_NONE   = 2'd0,
    EV_SINGLE = 2'd1,
    EV_DOUBLE = 2'd2,
    EV_LONG   = 2'd3
  } press_event_t;

endpackage

// File: rtl/press_timer.sv
// rtl/press_timer.sv - shared gesture counter with long-press and gap terminal compares
module press_timer #(
  parameter int LONG_CYCLES = 50_000_000,
  parameter int GAP_CYCLES  = 25_000_000,
  parameter int CNT_W       = $clog2(LONG_CYCLES > GAP_CYCLES ? LONG_CYCLES : GAP_CYCLES) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load1,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             at_long,
  output logic             at_gap
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // load1 wins: a new phase always restarts at one sample already seen
  always_comb begin
    cnt_d = cnt_q;
    if (load1)    cnt_d = CNT_W'(1);
    else if (inc) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt     = cnt_q;
  assign at_long = (cnt_q == CNT_W'(LONG_CYCLES - 1));
  assign at_gap  = (cnt_q == CNT_W'(GAP_CYCLES - 1));

endmodule

// File: rtl/press_classifier.sv
// rtl/press_classifier.sv - single/double/long press classifier for one debounced button
module press_classifier #(
  parameter int LONG_CYCLES = 50_000_000,
  parameter int GAP_CYCLES  = 25_000_000,
  parameter int CNT_W       = $clog2(LONG_CYCLES > GAP_CYCLES ? LONG_CYCLES : GAP_CYCLES) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic single_click,
  output logic double_click,
  output logic long_press,
  output logic held,
  output logic busy
);
  import press_pkg::*;

  localparam int MAX_CYCLES = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;

  press_state_t     state_q, state_d;
  press_event_t     ev_d;
  logic             load1, inc, at_long, at_gap, cnt_bad;
  logic [CNT_W-1:0] cnt;
  logic             single_q, double_q, long_q, held_q, busy_q;

  press_timer #(
    .LONG_CYCLES(LONG_CYCLES),
    .GAP_CYCLES (GAP_CYCLES),
    .CNT_W      (CNT_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load1  (load1),
    .inc    (inc),
    .cnt    (cnt),
    .at_long(at_long),
    .at_gap (at_gap)
  );

  // Unreachable in normal operation; recovers from a corrupted counter by abandoning the gesture
  assign cnt_bad = (cnt > CNT_W'(MAX_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    ev_d    = EV_NONE;
    load1   = 1'b0;
    inc     = 1'b0;
    case (state_q)
      ST_IDLE: if (btn) begin
        state_d = ST_PRESS1;
        load1   = 1'b1;
      end
      ST_PRESS1: begin
        if (!btn) begin
          state_d = ST_GAP;
          load1   = 1'b1;
        end else if (at_long) begin
          state_d = ST_LONG_HOLD;
          ev_d    = EV_LONG;
        end else begin
          inc = 1'b1;
        end
      end
      ST_GAP: begin
        if (btn) begin
          state_d = ST_PRESS2;
        end else if (at_gap) begin
          state_d = ST_IDLE;
          ev_d    = EV_SINGLE;
        end else begin
          inc = 1'b1;
        end
      end
      ST_PRESS2: if (!btn) begin
        state_d = ST_IDLE;
        ev_d    = EV_DOUBLE;
      end
      ST_LONG_HOLD: if (!btn) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (cnt_bad) begin
      state_d = ST_IDLE;
      ev_d    = EV_NONE;
      load1   = 1'b0;
      inc     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      single_q <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      held_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      single_q <= (ev_d == EV_SINGLE);
      double_q <= (ev_d == EV_DOUBLE);
      long_q   <= (ev_d == EV_LONG);
      held_q   <= (state_d == ST_LONG_HOLD);
      busy_q   <= (state_d != ST_IDLE);
    end
  end

  assign single_click = single_q;
  assign double_click = double_q;
  assign long_press   = long_q;
  assign held         = held_q;
  assign busy         = busy_q;

endmodule
